unary_stream_decoder: RTL
=========================

UNARY_STREAM_DECODER -- requirements
Module: unary_stream_decoder

Interface
REQ-001 Parameter INPUT_WIDTH, default 32: stream length in bits per frame, minimum 2.
REQ-002 Parameter COUNT_WIDTH, default $clog2(INPUT_WIDTH+1): width of all count and ones fields.
REQ-003 Parameter THRESHOLD, default INPUT_WIDTH/2: comparison point for early decision (bounds build only).
REQ-004 Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream strobe; in_bit is meaningful when high.
- in_bit  in  1  unary stream bit.
- in_ready  out  1  decoder accepts the bit this cycle.
- out_valid  out  1  completed frame count available.
- out_ones  out  COUNT_WIDTH  number of ones in the completed frame, 0..INPUT_WIDTH.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  frame partially received (count != 0).

Function
REQ-005 States: COLLECT and DONE; state encoding is registered.
REQ-006 A bit is accepted when in_valid && in_ready.
REQ-007 in_ready = (state==COLLECT) || out_ready; this is combinational from state and out_ready only.
REQ-008 COLLECT, accepted bit: ones <= ones + in_bit; count <= count + 1.
REQ-009 COLLECT, accepted bit with count==INPUT_WIDTH-1: out_ones <= ones + in_bit; state <= DONE; out_valid=1 the next cycle (latency 1 from last bit); count and ones clear to 0.
REQ-010 DONE: out_valid and out_ones hold stable until out_valid && out_ready.
REQ-011 DONE with handshake: state <= COLLECT; out_valid <= 0 the next cycle.
REQ-012 DONE with handshake and a simultaneous accepted bit: the bit becomes bit 0 of the next frame (count=1, ones=in_bit); no bit is lost.
REQ-013 DONE without out_ready: in_ready=0; in_valid is ignored and the counters are unchanged.
REQ-014 Frames with INPUT_WIDTH=1 gaps of in_valid low between bits have no effect on counts; the gap length is unbounded.
REQ-015 Arithmetic is unsigned in COUNT_WIDTH and is never saturated; ones<=count<=INPUT_WIDTH always holds.
REQ-016 busy=1 iff state==COLLECT and count!=0.

Reset
REQ-017 While reset is low: state=COLLECT; count=0; ones=0; out_ones=0; out_valid=0; busy=0.
REQ-018 Reset asserted mid-frame discards the partial frame; the first accepted bit after release is bit 0.
REQ-019 Reset asserted in DONE drops the pending result without handshake.

Configuration
REQ-020 Macro UNARY_DECODE_BOUNDS_EN compiles in the ports lower_bound (out, COUNT_WIDTH), upper_bound (out, COUNT_WIDTH), early_ge (out, 1), and early_lt (out, 1).
REQ-021 With UNARY_DECODE_BOUNDS_EN defined:
- lower_bound = ones.
- upper_bound = ones + (INPUT_WIDTH - count).
- early_ge = (lower_bound >= THRESHOLD).
- early_lt = (upper_bound < THRESHOLD).
- All four are combinational from registers and are valid in COLLECT.
- In DONE, lower_bound = upper_bound = out_ones.
REQ-022 Without UNARY_DECODE_BOUNDS_EN, the four ports and their logic are absent, and all other behaviour is identical.

Structure
REQ-023 The shared package unary_pkg holds the state enum typedef (COLLECT, DONE) and the count-width helper function; the ports use the module parameters.
REQ-024 One sub-module, unary_bounds_tracker, computes lower_bound, upper_bound, early_ge and early_lt; it is instantiated only under UNARY_DECODE_BOUNDS_EN.

Verification
REQ-025 32 consecutive strobes with in_bit=1 and out_ready=1 -> out_valid pulses for 1 cycle exactly one cycle after the 32nd bit; out_ones=32.
REQ-026 Pattern 1,0 repeated 16 times with random 0-3 cycle in_valid gaps -> out_ones=16; busy=1 from the first accepted bit until DONE.
REQ-027 Frame of 5 ones with out_ready=0 for 10 cycles -> out_valid and out_ones=5 held, in_ready=0, and bits offered during the stall are ignored; after out_ready=1 the next frame decodes independently.
REQ-028 Handshake cycle coinciding with in_valid=1 and in_bit=1, then 31 zeros -> the second frame reports out_ones=1.
REQ-029 reset low for 1 cycle after 20 accepted bits -> all outputs 0; the following full 32-bit all-zero frame reports out_ones=0.
REQ-030 With UNARY_DECODE_BOUNDS_EN and THRESHOLD=16:
- 16 ones -> early_ge=1 after the 16th bit.
- 17 zeros in a fresh frame -> upper_bound=15 and early_lt=1.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary stream decoder.
// Holds the two-state FSM enum and the count-width helper.
// No logic; no latency or backpressure of its own.
package unary_pkg;

    // COLLECT gathers frame bits; DONE holds a finished result until the
    // downstream takes it.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_e;

    // Bits needed to hold any value 0..w inclusive.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/unary_bounds_tracker.sv
// Early-decision bounds on the ones count of the frame being collected.
// Latency: purely combinational from the decoder registers.
// Backpressure: none; outputs simply follow the decoder state.
// Ports: state_i/count_i/ones_i/out_ones_i from the decoder registers;
//        lower_bound_o, upper_bound_o, early_ge_o, early_lt_o.
module unary_bounds_tracker
    import unary_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = count_width(INPUT_WIDTH),
    parameter int THRESHOLD   = INPUT_WIDTH / 2
) (
    input  state_e                 state_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    input  logic [COUNT_WIDTH-1:0] ones_i,
    input  logic [COUNT_WIDTH-1:0] out_ones_i,
    output logic [COUNT_WIDTH-1:0] lower_bound_o,
    output logic [COUNT_WIDTH-1:0] upper_bound_o,
    output logic                   early_ge_o,
    output logic                   early_lt_o
);

    localparam logic [COUNT_WIDTH-1:0] FRAME_LEN = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] THR       = COUNT_WIDTH'(THRESHOLD);

    // Once the frame is complete the answer is exact, so both bounds collapse
    // onto the latched result. While collecting, every remaining bit could
    // still be a one, which gives the upper bound.
    always_comb begin
        if (state_i == DONE) begin
            lower_bound_o = out_ones_i;
            upper_bound_o = out_ones_i;
        end else begin
            lower_bound_o = ones_i;
            upper_bound_o = ones_i + (FRAME_LEN - count_i);
        end
    end

    assign early_ge_o = (lower_bound_o >= THR);
    assign early_lt_o = (upper_bound_o <  THR);

endmodule

// File: rtl/unary_stream_decoder.sv
// Counts ones in fixed-length bit frames; result out 1 cycle after last bit.
// Latency: 1 cycle from the last accepted bit to out_valid.
// Backpressure: result held in DONE; in_ready low until out_ready.
// Ports: clk, reset (async active-low), in_valid/in_bit/in_ready stream in,
//        out_valid/out_ones/out_ready result out, busy (partial frame).
// Optional: define UNARY_DECODE_BOUNDS_EN to add lower_bound, upper_bound,
//        early_ge and early_lt outputs.
module unary_stream_decoder
    import unary_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = count_width(INPUT_WIDTH),
    parameter int THRESHOLD   = INPUT_WIDTH / 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [COUNT_WIDTH-1:0] out_ones,
    input  logic                   out_ready,
    output logic                   busy
`ifdef UNARY_DECODE_BOUNDS_EN
    ,
    output logic [COUNT_WIDTH-1:0] lower_bound,
    output logic [COUNT_WIDTH-1:0] upper_bound,
    output logic                   early_ge,
    output logic                   early_lt
`endif
);

    if (INPUT_WIDTH < 2 || THRESHOLD < 0 || THRESHOLD > INPUT_WIDTH) begin : g_param_check
        $error("unary_stream_decoder: INPUT_WIDTH must be >= 2 and THRESHOLD in 0..INPUT_WIDTH");
    end

    localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(INPUT_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] ones_q, ones_d;
    logic [COUNT_WIDTH-1:0] out_ones_q, out_ones_d;
    logic                   out_valid_q, out_valid_d;

    logic                   accept;
    logic [COUNT_WIDTH-1:0] bit_ext;

    // In DONE a bit can still be taken on the same cycle the result leaves,
    // so a back-to-back stream never stalls when the sink is ready.
    assign in_ready = (state_q == COLLECT) || out_ready;
    assign accept   = in_valid && in_ready;
    assign bit_ext  = {{(COUNT_WIDTH-1){1'b0}}, in_bit};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ones_d      = ones_q;
        out_ones_d  = out_ones_q;
        out_valid_d = out_valid_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (count_q == LAST_IDX) begin
                        out_ones_d  = ones_q + bit_ext;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                        count_d     = '0;
                        ones_d      = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                        ones_d  = ones_q + bit_ext;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = COLLECT;
                    out_valid_d = 1'b0;
                    // A bit arriving with the handshake opens the next frame.
                    if (in_valid) begin
                        count_d = COUNT_WIDTH'(1);
                        ones_d  = bit_ext;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            ones_q      <= '0;
            out_ones_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ones_q      <= ones_d;
            out_ones_q  <= out_ones_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ones  = out_ones_q;
    assign busy      = (state_q == COLLECT) && (count_q != '0);

`ifdef UNARY_DECODE_BOUNDS_EN
    unary_bounds_tracker #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .THRESHOLD   (THRESHOLD)
    ) u_bounds (
        .state_i       (state_q),
        .count_i       (count_q),
        .ones_i        (ones_q),
        .out_ones_i    (out_ones_q),
        .lower_bound_o (lower_bound),
        .upper_bound_o (upper_bound),
        .early_ge_o    (early_ge),
        .early_lt_o    (early_lt)
    );
`endif

endmodule
